// File: rtl/gcd_lcm_unit.sv
// Iterative GCD / LCM unit: subtract-based GCD and add-based LCM, one step per cycle.
// Optional watchdog on the step count, enabled by defining GCDLCM_WATCHDOG_EN.
module gcd_lcm_unit #(
  parameter int WIDTH    = 32,
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             op_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ans_data,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             op;

  // One extra bit on the LCM sums exposes the carry-out used for overflow
  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   sum_y;

  assign sum_x = {1'b0, x} + {1'b0, a_reg};
  assign sum_y = {1'b0, y} + {1'b0, b_reg};

`ifdef GCDLCM_WATCHDOG_EN
  localparam int CW = $clog2(MAX_ITER + 1);
  logic [CW-1:0] steps;
  logic          limit_hit;

  assign limit_hit = (steps == CW'(MAX_ITER));
`endif

  // Termination decision for the current CALC cycle
  logic             calc_finish;
  logic [WIDTH-1:0] calc_ans;
  logic             calc_ovf;

  always_comb begin
    calc_finish = 1'b0;
    calc_ans    = '0;
    calc_ovf    = 1'b0;
    if (a_reg == '0 || b_reg == '0) begin
      calc_finish = 1'b1;
      calc_ans    = op ? '0 : (a_reg | b_reg);
    end else if (x == y) begin
      calc_finish = 1'b1;
      calc_ans    = x;
`ifdef GCDLCM_WATCHDOG_EN
    end else if (limit_hit) begin
      calc_finish = 1'b1;
      calc_ovf    = 1'b1;
`endif
    end else if (op) begin
      if (x < y) begin
        calc_finish = sum_x[WIDTH];
      end else begin
        calc_finish = sum_y[WIDTH];
      end
      calc_ovf = calc_finish;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      ans_data <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      x        <= '0;
      y        <= '0;
      op       <= 1'b0;
`ifdef GCDLCM_WATCHDOG_EN
      steps    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= data_in;
            busy  <= 1'b1;
            state <= WAIT_B;
          end
        end

        WAIT_B: begin
          if (start) begin
            b_reg <= data_in;
            op    <= op_sel;
            x     <= a_reg;
            y     <= data_in;
`ifdef GCDLCM_WATCHDOG_EN
            steps <= '0;
`endif
            state <= CALC;
          end
        end

        CALC: begin
          if (calc_finish) begin
            ans_data <= calc_ans;
            ovf      <= calc_ovf;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            if (!op) begin
              if (x > y) begin
                x <= x - y;
              end else begin
                y <= y - x;
              end
            end else begin
              if (x < y) begin
                x <= sum_x[WIDTH-1:0];
              end else begin
                y <= sum_y[WIDTH-1:0];
              end
            end
`ifdef GCDLCM_WATCHDOG_EN
            steps <= steps + 1'b1;
`endif
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= data_in;
            busy  <= 1'b1;
            state <= WAIT_B;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Self-checking bench for gcd_lcm_unit: directed corner cases plus random operands
// checked against an arithmetic GCD/LCM model (Euclid modulo, a*b/gcd).
module tb_gcd_lcm_unit;

  localparam int WIDTH = 32;
`ifdef GCDLCM_WATCHDOG_EN
  localparam int MAX_ITER = 8;
`else
  localparam int MAX_ITER = 65535;
`endif
  localparam int CYCLE_LIMIT = 3000;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             op_sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ans_data;
  logic             ovf;

  int checks;
  int errors;
  int done_count;

  gcd_lcm_unit #(
    .WIDTH   (WIDTH),
    .MAX_ITER(MAX_ITER)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .op_sel  (op_sel),
    .busy    (busy),
    .done    (done),
    .ans_data(ans_data),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
  end

  function automatic longint unsigned gcdRef(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    if (a == 0 || b == 0) return a | b;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // LCM result and overflow flag: overflow whenever the true LCM does not fit WIDTH bits
  task automatic lcmRef(input longint unsigned a, input longint unsigned b,
                        output longint unsigned ans, output logic o);
    longint unsigned l;
    if (a == 0 || b == 0) begin
      ans = 0;
      o   = 1'b0;
    end else begin
      l = (a / gcdRef(a, b)) * b;
      if (l > 64'h0000_0000_FFFF_FFFF) begin
        ans = 0;
        o   = 1'b1;
      end else begin
        ans = l;
        o   = 1'b0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Strobe A, then B with op; returns at the negedge of cycle T+1
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic op);
    @(negedge clk);
    start   = 1'b1;
    data_in = a;
    @(negedge clk);
    data_in = b;
    op_sel  = op;
    @(negedge clk);
    start   = 1'b0;
    data_in = '0;
    op_sel  = 1'b0;
  endtask

  task automatic waitDone(input int first_cyc, output int cyc, output logic ok);
    cyc = first_cyc;
    ok  = 1'b0;
    while (cyc <= CYCLE_LIMIT) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic runCase(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic op, input logic [WIDTH-1:0] exp_ans, input logic exp_ovf,
                         input int exp_lat);
    int   cyc;
    logic ok;
    applyStimulus(a, b, op);
    checkOutput({tag, " busy"}, 64'(busy), 64'd1);
    waitDone(1, cyc, ok);
    checkOutput({tag, " done_seen"}, 64'(ok), 64'd1);
    if (exp_lat >= 0) checkOutput({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    checkOutput({tag, " ans"}, 64'(ans_data), 64'(exp_ans));
    checkOutput({tag, " ovf"}, 64'(ovf), 64'(exp_ovf));
    @(negedge clk);
    checkOutput({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int              cyc;
    logic            ok;
    int              snap;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic            rop;
    longint unsigned eans;
    logic            eovf;

    checks     = 0;
    errors     = 0;
    done_count = 0;
    reset      = 1'b1;
    start      = 1'b1;
    data_in    = 32'hDEAD_BEEF;
    op_sel     = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset ans", 64'(ans_data), 64'd0);
    checkOutput("reset ovf", 64'(ovf), 64'd0);
    start   = 1'b0;
    data_in = '0;
    reset   = 1'b0;

    runCase("gcd12_18", 32'd12, 32'd18, 1'b0, 32'd6, 1'b0, 4);
    runCase("lcm4_6", 32'd4, 32'd6, 1'b1, 32'd12, 1'b0, 5);
    runCase("gcd0_7", 32'd0, 32'd7, 1'b0, 32'd7, 1'b0, 2);
    runCase("lcm0_7", 32'd0, 32'd7, 1'b1, 32'd0, 1'b0, 2);
    runCase("gcd5_5", 32'd5, 32'd5, 1'b0, 32'd5, 1'b0, 2);

    snap = done_count;
    runCase("lcm_ovf", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 32'd0, 1'b1, 2);
    repeat (2) @(negedge clk);
    checkOutput("lcm_ovf pulses", 64'(done_count - snap), 64'd1);

    // Start arriving in DONE begins a new operation while done still pulses
    applyStimulus(32'd12, 32'd18, 1'b0);
    waitDone(1, cyc, ok);
    checkOutput("chain first done", 64'(ok), 64'd1);
    checkOutput("chain first ans", 64'(ans_data), 64'd6);
    start   = 1'b1;
    data_in = 32'd20;
    @(negedge clk);
    checkOutput("chain done drop", 64'(done), 64'd0);
    checkOutput("chain busy", 64'(busy), 64'd1);
    data_in = 32'd30;
    op_sel  = 1'b0;
    @(negedge clk);
    start   = 1'b0;
    data_in = '0;
    waitDone(1, cyc, ok);
    checkOutput("chain second done", 64'(ok), 64'd1);
    checkOutput("chain second latency", 64'(cyc), 64'd4);
    checkOutput("chain second ans", 64'(ans_data), 64'd10);
    @(negedge clk);

    // Reset mid-CALC abandons the operation
    applyStimulus(32'd1000, 32'd1, 1'b0);
    repeat (5) @(negedge clk);
    snap  = done_count;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort ans", 64'(ans_data), 64'd0);
    checkOutput("abort ovf", 64'(ovf), 64'd0);
    repeat (20) @(negedge clk);
    checkOutput("abort no done", 64'(done_count - snap), 64'd0);
    runCase("gcd9_6", 32'd9, 32'd6, 1'b0, 32'd3, 1'b0, 4);

    // Start pulses during CALC must be ignored
    applyStimulus(32'd100, 32'd1, 1'b0);
    start   = 1'b1;
    data_in = 32'd55;
    op_sel  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start   = 1'b0;
    data_in = '0;
    op_sel  = 1'b0;
    waitDone(3, cyc, ok);
    checkOutput("calc_ignore done", 64'(ok), 64'd1);
`ifdef GCDLCM_WATCHDOG_EN
    checkOutput("watchdog latency", 64'(cyc), 64'd10);
    checkOutput("watchdog ans", 64'(ans_data), 64'd0);
    checkOutput("watchdog ovf", 64'(ovf), 64'd1);
`else
    checkOutput("calc_ignore latency", 64'(cyc), 64'd101);
    checkOutput("calc_ignore ans", 64'(ans_data), 64'd1);
    checkOutput("calc_ignore ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      ra  = WIDTH'($urandom_range(0, 255));
      rb  = WIDTH'($urandom_range(0, 255));
      rop = 1'($urandom_range(0, 1));
      if (rop) begin
        lcmRef(64'(ra), 64'(rb), eans, eovf);
      end else begin
        eans = gcdRef(64'(ra), 64'(rb));
        eovf = 1'b0;
      end
`ifdef GCDLCM_WATCHDOG_EN
      // Small watchdog limit: only compare when the outcome is certain to finish in time
      if (ra == rb || ra == 0 || rb == 0) begin
        runCase($sformatf("rand%0d", i), ra, rb, rop, WIDTH'(eans), eovf, 2);
      end
`else
      runCase($sformatf("rand%0d", i), ra, rb, rop, WIDTH'(eans), eovf, -1);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_lcm_unit.md
GCD_LCM_UNIT -- requirements
Module: gcd_lcm_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter MAX_ITER, default 65535: watchdog step limit, used only when GCDLCM_WATCHDOG_EN is defined.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: operand strobe driven by the core's Start output.
REQ-006 SHALL have port data_in, input, WIDTH bits: operand value, the core's final write data.
REQ-007 SHALL have port op_sel, input, 1 bit: 0 selects GCD, 1 selects LCM; sampled together with operand B.
REQ-008 SHALL have port busy, output, 1 bit: high while in WAIT_B or CALC.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a result is valid.
REQ-010 SHALL have port ans_data, output, WIDTH bits: result, held until the next result or reset.
REQ-011 SHALL have port ovf, output, 1 bit: result invalid (overflow or watchdog); updated together with ans_data.

Function
REQ-012 SHALL implement the states IDLE, WAIT_B, CALC and DONE.
REQ-013 SHALL, on start in IDLE or DONE, latch data_in as A and go to WAIT_B.
REQ-014 SHALL, on start in WAIT_B, latch data_in as B and op_sel as op, then go to CALC.
REQ-015 SHALL ignore start while in CALC, with no effect on operands or state.
REQ-016 SHALL perform exactly one step per CALC cycle on working registers x, y, initialised to x=A, y=B.
REQ-017 SHALL, for a GCD step, set x=x-y if x>y, otherwise y=y-x.
REQ-018 SHALL, for an LCM step, set x=x+A if x<y, otherwise y=y+B, using WIDTH+1-bit sums.
REQ-019 SHALL terminate when, at the start of a CALC cycle, x==y: ans_data=x, ovf=0, go to DONE.
REQ-020 SHALL handle a zero operand with no steps: GCD gives ans=A|B; LCM gives ans=0; ovf=0 in both cases.
REQ-021 SHALL, if an LCM sum carries out of WIDTH bits, set ans_data=0 and ovf=1 and go to DONE.
REQ-022 SHALL give latency as follows: operand B strobed in cycle T, N steps taken, done high in cycle T+2+N.
REQ-023 SHALL assert done only in DONE, for exactly one cycle, then return to IDLE unless start is also high.
REQ-024 SHALL treat start in DONE as an IDLE start: done still pulses and A is latched.

Reset
REQ-025 SHALL, on reset high at a clock edge, go to IDLE and clear busy, done, ovf, ans_data, A, B, x, y and the step counter to 0, overriding start.
REQ-026 SHALL, on reset during WAIT_B or CALC, abandon the operation with no done pulse.

Configuration
REQ-027 SHALL, with GCDLCM_WATCHDOG_EN defined, count CALC steps; if MAX_ITER steps complete without termination, set ans_data=0, ovf=1 and go to DONE.
REQ-028 SHALL, without GCDLCM_WATCHDOG_EN, contain no step counter; termination is by equality, zero or overflow only.

Verification
REQ-029 SHALL cover: start A=12, start B=18, op=0 -> done at T+4, ans=6, ovf=0.
REQ-030 SHALL cover: start A=4, start B=6, op=1 -> done at T+5, ans=12, ovf=0.
REQ-031 SHALL cover: A=0, B=7, op=0 -> ans=7 at T+2; and A=0, B=7, op=1 -> ans=0 at T+2.
REQ-032 SHALL cover: A=0xFFFFFFFF, B=0xFFFFFFFE, op=1 -> ovf=1, ans=0, one done pulse.
REQ-033 SHALL cover: reset during CALC of GCD(1000,1) -> no done pulse, all outputs 0; a new GCD(9,6) then gives ans=3.
REQ-034 SHALL cover: with the macro and MAX_ITER=8, GCD(100,1) -> done after 8 steps with ovf=1, ans=0; start pulses during CALC ignored.
